// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO.
// MULT uses shift-add and DIV uses restoring division. Each takes WIDTH
// cycles and retires one multiplier or quotient bit per cycle.
// MTHI/MTLO write HI or LO in a single cycle.
// Optional feature: define MULDIV_SIGNED_EN to make op[2] select signed MULT/DIV.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] opnd_reg;     // multiplicand (MULT) or divisor (DIV)
  logic [WIDTH-1:0] acc_hi_reg;   // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo_reg;   // multiplier being shifted out / quotient shifted in
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dbz_reg;

  // Operand values loaded on accept (magnitudes when signed mode is active)
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;

`ifdef MULDIV_SIGNED_EN
  logic neg_lo_reg;   // negate product (MULT) or quotient (DIV) at completion
  logic neg_hi_reg;   // negate remainder at completion (DIV only)
  logic load_neg_lo;
  logic load_neg_hi;

  // Convert signed operands to magnitudes and note the result signs
  always_comb begin
    load_a      = src_a;
    load_b      = src_b;
    load_neg_lo = 1'b0;
    load_neg_hi = 1'b0;
    if (op[2]) begin
      if (src_a[WIDTH-1]) load_a = -src_a;
      if (src_b[WIDTH-1]) load_b = -src_b;
      load_neg_lo = src_a[WIDTH-1] ^ src_b[WIDTH-1];
      load_neg_hi = src_a[WIDTH-1];
    end
  end
`else
  // Unsigned-only build: the sign select bit has no effect
  logic unused_sign_bit;
  assign unused_sign_bit = op[2];

  // Operands pass through unchanged
  always_comb begin
    load_a = src_a;
    load_b = src_b;
  end
`endif

  // One iteration step of shift-add or restoring divide, plus final fixups
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  // Next accumulator value for the current state and the completed result
  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + {1'b0, opnd_reg};
    // The shifted remainder is WIDTH+1 bits wide. Its top bit is acc_hi_reg[WIDTH-1].
    // If that bit is set, the value always exceeds the divisor.
    div_shift = {acc_hi_reg[WIDTH-2:0], acc_lo_reg[WIDTH-1]};
    div_fits  = acc_hi_reg[WIDTH-1] | (div_shift >= opnd_reg);
    div_diff  = div_shift - opnd_reg;
    if (state_reg == DIV) begin
      if (div_fits) begin
        step_hi = div_diff;
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift;
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b0};
      end
    end else if (acc_lo_reg[0]) begin
      {step_hi, step_lo} = {mul_sum, acc_lo_reg[WIDTH-1:1]};
    end else begin
      {step_hi, step_lo} = {1'b0, acc_hi_reg, acc_lo_reg[WIDTH-1:1]};
    end

    fin_hi = step_hi;
    fin_lo = step_lo;
`ifdef MULDIV_SIGNED_EN
    if (state_reg == DIV) begin
      if (neg_lo_reg) fin_lo = -step_lo;
      if (neg_hi_reg) fin_hi = -step_hi;
    end else if (neg_lo_reg) begin
      {fin_hi, fin_lo} = -{step_hi, step_lo};
    end
`endif
    // With a zero divisor every trial subtraction succeeds. The remainder then
    // ends up equal to the dividend (re-signed above), so only the quotient
    // needs forcing.
    if ((state_reg == DIV) && (opnd_reg == '0)) fin_lo = '1;
  end

  // Controller, iteration datapath and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      opnd_reg   <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          if (start) begin
            dbz_reg <= 1'b0;
            case (op[1:0])
              2'b00: begin
                state_reg  <= MUL;
                busy_reg   <= 1'b1;
                count_reg  <= CW'(WIDTH - 1);
                opnd_reg   <= load_a;
                acc_hi_reg <= '0;
                acc_lo_reg <= load_b;
              end
              2'b01: begin
                state_reg  <= DIV;
                busy_reg   <= 1'b1;
                count_reg  <= CW'(WIDTH - 1);
                opnd_reg   <= load_b;
                acc_hi_reg <= '0;
                acc_lo_reg <= load_a;
              end
              2'b10:   hi_reg <= src_a;
              default: lo_reg <= src_a;
            endcase
`ifdef MULDIV_SIGNED_EN
            neg_lo_reg <= load_neg_lo;
            neg_hi_reg <= load_neg_hi;
`endif
          end
        end
        default: begin
          acc_hi_reg <= step_hi;
          acc_lo_reg <= step_lo;
          count_reg  <= count_reg - 1'b1;
          if (count_reg == '0) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            hi_reg    <= fin_hi;
            lo_reg    <= fin_lo;
            dbz_reg   <= (state_reg == DIV) && (opnd_reg == '0);
          end
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;
  assign div_by_zero = dbz_reg;

endmodule
